// File: rtl/dp_timing_pkg.sv
// Shared types and constants for the DP video timing / test-pattern generator.
package dp_timing_pkg;

    localparam int unsigned     CntW      = 16;
    localparam int unsigned     CwDefault = 8;
    localparam logic [CntW-1:0] MinTotal  = 16'd2;

    // Bar index bits map directly onto {R,G,B} on/off.
    localparam logic [2:0] BarColours [8] = '{
        3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111
    };

    typedef struct packed {
        logic [CntW-1:0] h_start;
        logic [CntW-1:0] h_end;
        logic [CntW-1:0] v_start;
        logic [CntW-1:0] v_end;
    } win_t;

    typedef struct packed {
        logic [CntW-1:0] width;
        logic [CntW-1:0] height;
        logic [CntW-1:0] aws;
        logic [CntW-1:0] ahs;
        logic [CntW-1:0] bw;
        logic            internal;
        win_t            hs;
        win_t            vs;
    } timing_cfg_t;

    function automatic logic [CntW-1:0] clamp_total(input logic [CntW-1:0] v);
        return (v < MinTotal) ? MinTotal : v;
    endfunction

    function automatic logic [CntW-1:0] bar_width(input logic [CntW-1:0] total,
                                                  input logic [CntW-1:0] start);
        logic [CntW-1:0] bw;
        bw = (start < total) ? ((total - start) >> 3) : '0;
        return (bw == '0) ? 16'd1 : bw;
    endfunction

endpackage

// File: rtl/dp_win_cmp.sv
// Half-open rectangular window decode over the h/v counters; START >= END never matches.
module dp_win_cmp
    import dp_timing_pkg::*;
(
    input  logic [CntW-1:0] h_start_i,
    input  logic [CntW-1:0] h_end_i,
    input  logic [CntW-1:0] v_start_i,
    input  logic [CntW-1:0] v_end_i,
    input  logic [CntW-1:0] hcnt_i,
    input  logic [CntW-1:0] vcnt_i,
    output logic            active_o
);

    always_comb begin
        active_o = (hcnt_i >= h_start_i) && (hcnt_i < h_end_i) &&
                   (vcnt_i >= v_start_i) && (vcnt_i < v_end_i);
    end

endmodule

// File: rtl/dp_timing_gen.sv
// DP video timing and test-pattern generator; config is shadowed and swapped only at
// the frame boundary so register writes never tear a frame.
module dp_timing_gen
    import dp_timing_pkg::*;
#(
    parameter logic        HSYNC_POL = 1'b1,
    parameter logic        VSYNC_POL = 1'b1,
    parameter int unsigned CW        = CwDefault
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            SOFT_RESET,
    input  logic [15:0]     HEIGHT,
    input  logic [15:0]     WIDTH,
    input  logic [15:0]     ACTIVE_HEIGHT_START,
    input  logic [15:0]     ACTIVE_WIDTH_START,
    input  logic [15:0]     VSYNC_VCOUNT_START,
    input  logic [15:0]     VSYNC_VCOUNT_END,
    input  logic [15:0]     VSYNC_HCOUNT_START,
    input  logic [15:0]     VSYNC_HCOUNT_END,
    input  logic [15:0]     HSYNC_VCOUNT_START,
    input  logic [15:0]     HSYNC_VCOUNT_END,
    input  logic [15:0]     HSYNC_HCOUNT_START,
    input  logic [15:0]     HSYNC_HCOUNT_END,
    input  logic [15:0]     R,
    input  logic [15:0]     G,
    input  logic [15:0]     B,
    input  logic            INTERNAL,
    output logic            HSYNC,
    output logic            VSYNC,
    output logic            DE,
    output logic [3*CW-1:0] PIXEL,
    output logic            SOF
);

    timing_cfg_t     cfg_q, cfg_d;
    logic [3*CW-1:0] solid_q, solid_d;
    logic [CntW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [CntW-1:0] bar_cnt_q, bar_cnt_d, bar_cnt_cur;
    logic [2:0]      bar_idx_q, bar_idx_d, bar_idx_cur, bar_rgb;
    logic            hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, sof_q, sof_d;
    logic [3*CW-1:0] pixel_q, pixel_d;
    logic            rst, last_pix, last_line, load;
    logic            hs_act, vs_act, de_c, line_first;

    always_comb begin
        rst       = ~RST_N | SOFT_RESET;
        last_pix  = (hcnt_q == cfg_q.width - 16'd1);
        last_line = (vcnt_q == cfg_q.height - 16'd1);
        load      = rst | (last_pix & last_line);
    end

    always_comb begin
        cfg_d   = cfg_q;
        solid_d = solid_q;
        if (load) begin
            cfg_d.width     = clamp_total(WIDTH);
            cfg_d.height    = clamp_total(HEIGHT);
            cfg_d.aws       = ACTIVE_WIDTH_START;
            cfg_d.ahs       = ACTIVE_HEIGHT_START;
            cfg_d.bw        = bar_width(clamp_total(WIDTH), ACTIVE_WIDTH_START);
            cfg_d.internal  = INTERNAL;
            cfg_d.hs        = '{HSYNC_HCOUNT_START, HSYNC_HCOUNT_END,
                                HSYNC_VCOUNT_START, HSYNC_VCOUNT_END};
            cfg_d.vs        = '{VSYNC_HCOUNT_START, VSYNC_HCOUNT_END,
                                VSYNC_VCOUNT_START, VSYNC_VCOUNT_END};
            solid_d         = {R[CW-1:0], G[CW-1:0], B[CW-1:0]};
        end
    end

    dp_win_cmp u_hs_win (
        .h_start_i (cfg_q.hs.h_start),
        .h_end_i   (cfg_q.hs.h_end),
        .v_start_i (cfg_q.hs.v_start),
        .v_end_i   (cfg_q.hs.v_end),
        .hcnt_i    (hcnt_q),
        .vcnt_i    (vcnt_q),
        .active_o  (hs_act)
    );

    dp_win_cmp u_vs_win (
        .h_start_i (cfg_q.vs.h_start),
        .h_end_i   (cfg_q.vs.h_end),
        .v_start_i (cfg_q.vs.v_start),
        .v_end_i   (cfg_q.vs.v_end),
        .hcnt_i    (hcnt_q),
        .vcnt_i    (vcnt_q),
        .active_o  (vs_act)
    );

    always_comb begin
        hcnt_d = last_pix ? '0 : hcnt_q + 16'd1;
        vcnt_d = vcnt_q;
        if (last_pix) begin
            vcnt_d = last_line ? '0 : vcnt_q + 16'd1;
        end

        de_c       = (hcnt_q >= cfg_q.aws) && (vcnt_q >= cfg_q.ahs);
        line_first = (hcnt_q == cfg_q.aws) && (vcnt_q >= cfg_q.ahs);

        // The first active pixel of a line sees a fresh bar state, not last line's leftovers.
        bar_cnt_cur = line_first ? '0 : bar_cnt_q;
        bar_idx_cur = line_first ? '0 : bar_idx_q;
        bar_cnt_d   = bar_cnt_q;
        bar_idx_d   = bar_idx_q;
        if (de_c) begin
            if (bar_cnt_cur == cfg_q.bw - 16'd1) begin
                bar_cnt_d = '0;
                bar_idx_d = (bar_idx_cur == 3'd7) ? 3'd7 : bar_idx_cur + 3'd1;
            end else begin
                bar_cnt_d = bar_cnt_cur + 16'd1;
                bar_idx_d = bar_idx_cur;
            end
        end
        bar_rgb = BarColours[bar_idx_cur];

        hsync_d = hs_act ? HSYNC_POL : ~HSYNC_POL;
        vsync_d = vs_act ? VSYNC_POL : ~VSYNC_POL;
        de_d    = de_c;
        sof_d   = (hcnt_q == cfg_q.aws) && (vcnt_q == cfg_q.ahs);
        pixel_d = '0;
        if (de_c) begin
            pixel_d = cfg_q.internal ? solid_q
                                     : {{CW{bar_rgb[2]}}, {CW{bar_rgb[1]}}, {CW{bar_rgb[0]}}};
        end
    end

    always_ff @(posedge CLK) begin
        cfg_q   <= cfg_d;
        solid_q <= solid_d;
        if (rst) begin
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
            hsync_q   <= ~HSYNC_POL;
            vsync_q   <= ~VSYNC_POL;
            de_q      <= 1'b0;
            sof_q     <= 1'b0;
            pixel_q   <= '0;
        end else begin
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            de_q      <= de_d;
            sof_q     <= sof_d;
            pixel_q   <= pixel_d;
        end
    end

    if (CW < CntW) begin : g_unused_hi
        logic unused_colour_hi;
        assign unused_colour_hi = ^{R[CntW-1:CW], G[CntW-1:CW], B[CntW-1:CW]};
    end

    assign HSYNC = hsync_q;
    assign VSYNC = vsync_q;
    assign DE    = de_q;
    assign PIXEL = pixel_q;
    assign SOF   = sof_q;

endmodule
